adel_imem_loader: RTL and testbench

- Instruction-side front end for the adel core: holds the program store, receives a program byte-serially over a valid/ready link, and supplies the core's 16-bit instruction for its current PC.
- Combinational read: inst follows pc in the same cycle. The core needs this because it executes the instruction at pc on every edge.
- Owns the core reset. The core is held in reset until a complete, accepted program is resident.

---
 rtl/adel_pkg.sv | 26 ++
 rtl/adel_imem.sv | 45 ++++
 rtl/adel_imem_loader.sv | 139 +++++++++++++
 tb/tb_adel_imem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adel_pkg.sv
// Shared definitions for the adel instruction-memory loader: loader FSM
// states, default store geometry and the halt instruction returned for
// unloaded words.
package adel_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = 8;
    localparam int INST_W     = 16;

    // Decodes in the core as branch-if-zero by 0: a self-loop halt.
    localparam logic [INST_W-1:0] HALT_INST = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        LD_HI,
        LD_LO,
        CHK,
        RUN
    } ld_state_t;

    // States in which the loader is consuming bytes from the link.
    function automatic logic is_loading(ld_state_t s);
        return (s == LD_HI) || (s == LD_LO) || (s == CHK);
    endfunction

endpackage

// File: rtl/adel_imem.sv
// Program store: DEPTH x 16-bit words plus a per-word valid bitmap.
// Ports: clk/nrst, clr (bulk-clear valid bits), we/waddr/wdata (single write
// port), raddr/rdata (asynchronous read; unloaded words read as HALT_INST).
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none, always accepts writes.
module adel_imem
    import adel_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    // Storage has no reset; only the valid bitmap decides what is readable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Clear takes priority so a restart can never leave a stale word marked.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (we) begin
            valid[waddr] <= 1'b1;
        end
    end

    assign rdata = valid[raddr] ? mem[raddr] : HALT_INST;

endmodule

// File: rtl/adel_imem_loader.sv
// Instruction front end for the adel core: loads a program byte-serially
// (high byte first) into adel_imem, serves inst for pc combinationally, and
// holds the core in reset until a complete program is resident.
// Ports: clk/nrst, ld_start/ld_len (begin a load), ld_data/ld_valid/ld_ready
// (byte link), pc/inst (read path), core_nrst/busy/done/err (status).
// Latency: inst follows pc in the same cycle; done/core_nrst rise on the edge
// accepting the final byte. Backpressure: ld_ready high only while loading.
// Optional: define ADEL_IMEM_CHECKSUM_EN to require a trailing XOR checksum
// byte before the core is released.
module adel_imem_loader
    import adel_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ld_start,
    input  logic [AW:0]       ld_len,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     pc,
    output logic [INST_W-1:0] inst,
    output logic              core_nrst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    ld_state_t   state, state_nxt;
    logic [AW:0] cnt;
    logic [AW:0] len;
    logic [7:0]  hi;
    logic        len_ok;
    logic        xfer;
    logic        last;
    logic        we;
    logic        chk_fail;

    assign len_ok = (ld_len != '0) && (ld_len <= LEN_MAX);
    assign xfer   = ld_valid && ld_ready;
    // Counter is AW+1 bits so a full-depth load ends without wrapping.
    assign last   = ((cnt + CNT_ONE) == len);
    // ld_start wins over a simultaneous byte: the byte is dropped.
    assign we     = (state == LD_LO) && xfer && !ld_start;

`ifdef ADEL_IMEM_CHECKSUM_EN
    logic [7:0] xsum;
    assign chk_fail = (state == CHK) && xfer && !ld_start && (ld_data != xsum);
`else
    assign chk_fail = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (ld_start) begin
            // A malformed request abandons whatever was loaded or running.
            state_nxt = len_ok ? LD_HI : IDLE;
        end else begin
            case (state)
                LD_HI: if (xfer) state_nxt = LD_LO;
                LD_LO: begin
                    if (xfer) begin
`ifdef ADEL_IMEM_CHECKSUM_EN
                        state_nxt = last ? CHK : LD_HI;
`else
                        state_nxt = last ? RUN : LD_HI;
`endif
                    end
                end
                CHK:   if (xfer) state_nxt = chk_fail ? IDLE : RUN;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            core_nrst <= 1'b0;
            ld_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            len       <= '0;
            hi        <= '0;
        end else begin
            state     <= state_nxt;
            core_nrst <= (state_nxt == RUN);
            done      <= (state_nxt == RUN);
            busy      <= is_loading(state_nxt);
            ld_ready  <= is_loading(state_nxt);
            if (ld_start) begin
                err <= !len_ok;
                if (len_ok) begin
                    cnt <= '0;
                    len <= ld_len;
                end
            end else if (xfer) begin
                if (state == LD_HI) hi <= ld_data;
                if (state == LD_LO && !last) cnt <= cnt + CNT_ONE;
                if (chk_fail) err <= 1'b1;
            end
        end
    end

`ifdef ADEL_IMEM_CHECKSUM_EN
    // Running XOR of every program byte, compared against the trailing byte.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            xsum <= '0;
        end else if (ld_start) begin
            xsum <= '0;
        end else if (xfer && (state == LD_HI || state == LD_LO)) begin
            xsum <= xsum ^ ld_data;
        end
    end
`endif

    adel_imem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (ld_start || chk_fail),
        .we    (we),
        .waddr (cnt[AW-1:0]),
        .wdata ({hi, ld_data}),
        .raddr (pc),
        .rdata (inst)
    );

endmodule

// File: tb/tb_adel_imem_loader.sv
module tb_adel_imem_loader;

    logic        clk;
    logic        nrst;
    logic        ld_start;
    logic [8:0]  ld_len;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic        core_nrst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    adel_imem_loader #(.DEPTH(256), .AW(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ld_start  (ld_start),
        .ld_len    (ld_len),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .pc        (pc),
        .inst      (inst),
        .core_nrst (core_nrst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] len);
        ld_start = 1'b1;
        ld_len   = len;
        tick();
        ld_start = 1'b0;
    endtask

    // Presents one byte and returns 1 time unit after the edge that took it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ld_data  = b;
        ld_valid = 1'b1;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!ld_ready) begin
            errors++;
            $display("FAIL send_byte timeout: ld_ready=%0b, required 1", ld_ready);
        end else begin
            tick();
        end
    endtask

    // Trailing checksum byte exists only when the checksum feature is built.
    task automatic send_csum(input logic [7:0] x);
`ifdef ADEL_IMEM_CHECKSUM_EN
        send_byte(x);
`else
        x = x;
`endif
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) tick();
        checks += 4;
        if (core_nrst !== 1'b0) begin errors++; $display("FAIL reset core_nrst: got %b, required 0", core_nrst); end
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset ld_ready: got %b, required 0", ld_ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b, required 0", done); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b, required 0", err); end
        for (int i = 0; i < 3; i++) begin
            pc = (i == 0) ? 8'd0 : (i == 1) ? 8'd77 : 8'd255;
            #1;
            checks++;
            if (inst !== 16'h0000) begin errors++; $display("FAIL reset inst pc=%0d: got %h, required 0000", pc, inst); end
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic check_load2(input string tag);
        pc = 8'd0; #1;
        checks++;
        if (inst !== 16'h8005) begin errors++; $display("FAIL %s inst pc=0: got %h, required 8005", tag, inst); end
        pc = 8'd1; #1;
        checks++;
        if (inst !== 16'h0000) begin errors++; $display("FAIL %s inst pc=1: got %h, required 0000", tag, inst); end
        pc = 8'd2; #1;
        checks++;
        if (inst !== 16'h0000) begin errors++; $display("FAIL %s inst pc=2: got %h, required 0000", tag, inst); end
    endtask

    task automatic test_back_to_back();
        do_start(9'd2);
        checks += 2;
        if (busy !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL b2b start busy/ready: got %b%b, required 11", busy, ld_ready); end
        if (core_nrst !== 1'b0) begin errors++; $display("FAIL b2b start core_nrst: got %b, required 0", core_nrst); end
        send_byte(8'h80);
        send_byte(8'h05);
        send_byte(8'h00);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b early done: got %b, required 0", done); end
        send_byte(8'h00);
        send_csum(8'h85);
        ld_valid = 1'b0;
        checks += 2;
        if (done !== 1'b1 || core_nrst !== 1'b1) begin errors++; $display("FAIL b2b done/core_nrst: got %b%b, required 11", done, core_nrst); end
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b busy: got %b, required 0", busy); end
        check_load2("b2b");
    endtask

    task automatic test_valid_toggle();
        logic [7:0] bytes [4];
        bytes[0] = 8'h80; bytes[1] = 8'h05; bytes[2] = 8'h00; bytes[3] = 8'h00;
        do_start(9'd2);
        checks++;
        if (core_nrst !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL toggle restart from RUN: core_nrst/done %b%b, required 00", core_nrst, done); end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            ld_data  = 8'hEE;
            tick();
            send_byte(bytes[i]);
        end
        send_csum(8'h85);
        ld_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL toggle done: got %b, required 1", done); end
        check_load2("toggle");
    endtask

    task automatic test_restart();
        do_start(9'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        // Restart while in LD_LO of word 1, with a byte offered on the same edge.
        ld_data  = 8'hDD;
        ld_valid = 1'b1;
        do_start(9'd1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart busy/done: got %b%b, required 10", busy, done); end
        send_byte(8'h12);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL restart early done: got %b, required 0", done); end
        send_byte(8'h34);
        send_csum(8'h26);
        ld_valid = 1'b0;
        pc = 8'd0; #1;
        checks += 3;
        if (inst !== 16'h1234) begin errors++; $display("FAIL restart inst pc=0: got %h, required 1234", inst); end
        pc = 8'd1; #1;
        if (inst !== 16'h0000) begin errors++; $display("FAIL restart inst pc=1: got %h, required 0000", inst); end
        if (done !== 1'b1) begin errors++; $display("FAIL restart done: got %b, required 1", done); end
    endtask

    task automatic test_midload_reset();
        do_start(9'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        ld_valid = 1'b0;
        nrst = 1'b0;
        tick();
        pc = 8'd0; #1;
        checks += 2;
        if (inst !== 16'h0000) begin errors++; $display("FAIL midreset inst: got %h, required 0000", inst); end
        if (core_nrst !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("FAIL midreset status: got %b%b%b, required 000", core_nrst, busy, ld_ready); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_bad_len();
        do_start(9'd0);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL len0 err: got %b, required 1", err); end
        if (busy !== 1'b0 || ld_ready !== 1'b0 || core_nrst !== 1'b0) begin errors++; $display("FAIL len0 idle: got %b%b%b, required 000", busy, ld_ready, core_nrst); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err sticky: got %b, required 1", err); end
        do_start(9'd257);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len257 err/busy: got %b%b, required 10", err, busy); end
    endtask

    task automatic test_full_depth();
        logic [7:0] x = 8'h00;
        do_start(9'd256);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full start err/busy: got %b%b, required 01", err, busy); end
        for (int w = 0; w < 256; w++) begin
            send_byte(8'(w));
            if (w == 255) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL full early done: got %b, required 0", done); end
            end
            send_byte(8'(w) ^ 8'h5A);
            x = x ^ 8'(w) ^ (8'(w) ^ 8'h5A);
        end
        send_csum(x);
        ld_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || core_nrst !== 1'b1) begin errors++; $display("FAIL full done/core_nrst: got %b%b, required 11", done, core_nrst); end
        pc = 8'd255; #1;
        checks++;
        if (inst !== 16'hFFA5) begin errors++; $display("FAIL full inst pc=255: got %h, required FFA5", inst); end
        pc = 8'd0; #1;
        checks++;
        if (inst !== 16'h005A) begin errors++; $display("FAIL full inst pc=0: got %h, required 005A", inst); end
        pc = 8'd128; #1;
        checks++;
        if (inst !== 16'h80DA) begin errors++; $display("FAIL full inst pc=128: got %h, required 80DA", inst); end
    endtask

`ifdef ADEL_IMEM_CHECKSUM_EN
    task automatic test_checksum();
        do_start(9'd1);
        send_byte(8'hA5);
        send_byte(8'h0F);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL chk wait busy/done: got %b%b, required 10", busy, done); end
        send_byte(8'hAA);
        ld_valid = 1'b0;
        pc = 8'd0; #1;
        checks += 2;
        if (done !== 1'b1 || core_nrst !== 1'b1) begin errors++; $display("FAIL chk good done/core_nrst: got %b%b, required 11", done, core_nrst); end
        if (inst !== 16'hA50F) begin errors++; $display("FAIL chk good inst: got %h, required A50F", inst); end
        do_start(9'd1);
        send_byte(8'hA5);
        send_byte(8'h0F);
        send_byte(8'hAB);
        ld_valid = 1'b0;
        #1;
        checks += 3;
        if (err !== 1'b1) begin errors++; $display("FAIL chk bad err: got %b, required 1", err); end
        if (core_nrst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL chk bad core_nrst/busy: got %b%b, required 00", core_nrst, busy); end
        if (inst !== 16'h0000) begin errors++; $display("FAIL chk bad inst: got %h, required 0000", inst); end
    endtask
`endif

    initial begin
        nrst     = 1'b0;
        ld_start = 1'b0;
        ld_len   = '0;
        ld_data  = '0;
        ld_valid = 1'b0;
        pc       = '0;
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_restart();
        test_midload_reset();
        test_bad_len();
        test_full_depth();
`ifdef ADEL_IMEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
